// File: rtl/i2c_slave.sv
// 7-bit-address I2C target exchanging one 12-bit word per transaction
// as two bytes on the wire; SCL is observed only, SDA is open-drain.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    input  logic [11:0] tx_data,
    output logic [11:0] rx_data,
    output logic        rx_valid,
    output logic        tx_done,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, RX_B1, RX_ACK1, RX_B2, RX_ACK2,
        TX_B1, TX_ACK1, TX_B2, TX_ACK2, WAIT_STOP
    } state_t;

    logic [1:0]  scl_sync, sda_sync;
    logic        scl_prev, sda_prev;
    logic        scl_s, sda_s;
    logic        scl_rise, scl_fall, start_cond, stop_cond;

    state_t      state, state_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic [6:0]  shift, shift_next;
    logic        rw, rw_next;
    logic [11:0] shadow, shadow_next;
    logic [11:0] rx_hold, rx_hold_next;
    logic [11:0] rx_data_next;
    logic        rx_valid_next, tx_done_next, busy_next;
    logic        sda_low, sda_low_next;
    logic [7:0]  tx_byte;

    // Idle bus level is high, so the synchronizers reset to 1 to avoid false edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign scl_s      = scl_sync[1];
    assign sda_s      = sda_sync[1];
    assign scl_rise   = scl_s & ~scl_prev;
    assign scl_fall   = ~scl_s & scl_prev;
    assign start_cond = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_cond  = scl_s & scl_prev & ~sda_prev & sda_s;

    assign sda = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            rw       <= 1'b0;
            shadow   <= '0;
            rx_hold  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_done  <= 1'b0;
            busy     <= 1'b0;
            sda_low  <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            shift    <= shift_next;
            rw       <= rw_next;
            shadow   <= shadow_next;
            rx_hold  <= rx_hold_next;
            rx_data  <= rx_data_next;
            rx_valid <= rx_valid_next;
            tx_done  <= tx_done_next;
            busy     <= busy_next;
            sda_low  <= sda_low_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;
        rw_next       = rw;
        shadow_next   = shadow;
        rx_hold_next  = rx_hold;
        rx_data_next  = rx_data;
        rx_valid_next = 1'b0;
        tx_done_next  = 1'b0;
        busy_next     = busy;
        sda_low_next  = sda_low;
        tx_byte       = (state == TX_B1) ? shadow[11:4] : {shadow[3:0], 4'h0};

        if (start_cond) begin
            state_next   = ADDR;
            bit_cnt_next = '0;
            sda_low_next = 1'b0;
            busy_next    = 1'b0;
        end else if (stop_cond) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            sda_low_next = 1'b0;
            busy_next    = 1'b0;
        end else begin
            unique case (state)
                IDLE, WAIT_STOP: sda_low_next = 1'b0;
                ADDR: if (scl_rise) begin
                    shift_next   = {shift[5:0], sda_s};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (shift == SLAVE_ADDR) begin
                            state_next = ADDR_ACK;
                            busy_next  = 1'b1;
                            rw_next    = sda_s;
                            if (sda_s) shadow_next = tx_data;
                        end else begin
                            state_next = WAIT_STOP;
                        end
                    end
                end
                // Slave ACK: first fall pulls low, second fall releases and moves on.
                ADDR_ACK, RX_ACK1, RX_ACK2: if (scl_fall) begin
                    if (!sda_low) begin
                        sda_low_next = 1'b1;
                    end else begin
                        sda_low_next = 1'b0;
                        if (state == ADDR_ACK && rw) begin
                            state_next   = TX_B1;
                            sda_low_next = ~shadow[11];
                        end else if (state == ADDR_ACK) begin
                            state_next = RX_B1;
                        end else if (state == RX_ACK1) begin
                            state_next = RX_B2;
                        end else begin
                            state_next    = WAIT_STOP;
                            rx_data_next  = rx_hold;
                            rx_valid_next = 1'b1;
                        end
                    end
                end
                RX_B1: if (scl_rise) begin
                    rx_hold_next[11:4] = {rx_hold[10:4], sda_s};
                    bit_cnt_next       = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = RX_ACK1;
                end
                RX_B2: if (scl_rise) begin
                    if (!bit_cnt[2]) rx_hold_next[3:0] = {rx_hold[2:0], sda_s};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = RX_ACK2;
                end
                TX_B1, TX_B2: begin
                    if (scl_fall) sda_low_next = ~tx_byte[3'd7 - bit_cnt];
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state_next = (state == TX_B1) ? TX_ACK1 : TX_ACK2;
                    end
                end
                TX_ACK1: begin
                    if (scl_fall) sda_low_next = 1'b0;
                    if (scl_rise) state_next = sda_s ? WAIT_STOP : TX_B2;
                end
                TX_ACK2: begin
                    if (scl_fall) sda_low_next = 1'b0;
                    if (scl_rise) begin
                        tx_done_next = 1'b1;
                        state_next   = WAIT_STOP;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    sda_low_next = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged bus master drives scl/sda and
// checks ACKs, returned bytes and the local-side outputs.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int Q = 40;  // quarter of an SCL bit period

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        m_sda_low = 1'b0;
    logic [11:0] tx_data = '0;
    logic [11:0] rx_data;
    logic        rx_valid, tx_done, busy;
    wire         sda;

    int n_cmp = 0;
    int n_bad = 0;
    int rx_valid_cnt = 0;
    int tx_done_cnt = 0;
    int slave_low_cnt = 0;
    int scl_high_change = 0;
    logic prev_scl = 1'b1;
    logic prev_drv = 1'b0;
    logic slave_drv;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave #(.SLAVE_ADDR(7'h5A)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda), .tx_data(tx_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_done(tx_done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rx_valid_cnt++;
        if (tx_done) tx_done_cnt++;
        slave_drv = (sda === 1'b0) && !m_sda_low;
        if (slave_drv) slave_low_cnt++;
        if (scl && prev_scl && (slave_drv != prev_drv)) scl_high_change++;
        prev_scl = scl;
        prev_drv = slave_drv;
    end

    task automatic m_start();
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #Q;
        m_sda_low = 1'b1; #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic m_stop();
        m_sda_low = 1'b1; #Q;
        scl = 1'b1;       #Q;
        m_sda_low = 1'b0; #(2*Q);
    endtask

    task automatic m_bit_out(input logic b);
        m_sda_low = !b; #Q;
        scl = 1'b1;     #(2*Q);
        scl = 1'b0;     #Q;
    endtask

    task automatic m_bit_in(output logic b);
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #Q;
        b = (sda !== 1'b0); #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic m_write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) m_bit_out(d[i]);
        m_bit_in(b);
        ack = !b;
    endtask

    task automatic m_read_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            m_bit_in(b);
            d[i] = b;
        end
        m_bit_out(!ack);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        #25;
        n_cmp++; if (sda !== 1'b1)      begin n_bad++; $display("FAIL reset_sda: got %b, expected 1", sda); end
        n_cmp++; if (rx_data !== 12'h0) begin n_bad++; $display("FAIL reset_rx_data: got %h, expected 000", rx_data); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b, expected 0", rx_valid); end
        n_cmp++; if (tx_done !== 1'b0)  begin n_bad++; $display("FAIL reset_tx_done: got %b, expected 0", tx_done); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        int rv0 = rx_valid_cnt;
        m_start();
        m_write_byte(8'hB4, a0);
        m_write_byte(8'hAB, a1);
        m_write_byte(8'hC0, a2);
        n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_bad++; $display("FAIL write_acks: got %b, expected 111", {a0, a1, a2}); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL write_busy_before_stop: got %b, expected 1", busy); end
        m_stop();
        n_cmp++; if (rx_valid_cnt - rv0 != 1) begin n_bad++; $display("FAIL write_rx_valid_pulses: got %0d, expected 1", rx_valid_cnt - rv0); end
        n_cmp++; if (rx_data !== 12'hABC) begin n_bad++; $display("FAIL write_rx_data: got %h, expected abc", rx_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL write_busy_after_stop: got %b, expected 0", busy); end
    endtask

    task automatic test_read();
        logic a0;
        logic [7:0] b1, b2;
        int td0 = tx_done_cnt;
        tx_data = 12'h3D7;
        m_start();
        m_write_byte(8'hB5, a0);
        tx_data = 12'hFFF;  // must not affect the word in flight
        m_read_byte(1'b1, b1);
        m_read_byte(1'b0, b2);
        repeat (4) @(negedge clk);
        n_cmp++; if (a0 !== 1'b1) begin n_bad++; $display("FAIL read_addr_ack: got %b, expected 1", a0); end
        n_cmp++; if (b1 !== 8'h3D) begin n_bad++; $display("FAIL read_byte1: got %h, expected 3d", b1); end
        n_cmp++; if (b2 !== 8'h70) begin n_bad++; $display("FAIL read_byte2: got %h, expected 70", b2); end
        n_cmp++; if ({b1, b2[7:4]} !== 12'h3D7) begin n_bad++; $display("FAIL read_word: got %h, expected 3d7", {b1, b2[7:4]}); end
        n_cmp++; if (tx_done_cnt - td0 != 1) begin n_bad++; $display("FAIL read_tx_done_pulses: got %0d, expected 1", tx_done_cnt - td0); end
        n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL read_sda_after_nack: got %b, expected 1", sda); end
        m_stop();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL read_busy_after_stop: got %b, expected 0", busy); end
    endtask

    task automatic test_mismatch();
        logic a0, a1, a2;
        int rv0 = rx_valid_cnt;
        int sl0 = slave_low_cnt;
        m_start();
        m_write_byte(8'h44, a0);
        m_write_byte(8'h12, a1);
        m_write_byte(8'h30, a2);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mismatch_busy: got %b, expected 0", busy); end
        m_stop();
        n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_bad++; $display("FAIL mismatch_acks: got %b, expected 000", {a0, a1, a2}); end
        n_cmp++; if (slave_low_cnt - sl0 != 0) begin n_bad++; $display("FAIL mismatch_sda_driven: got %0d cycles, expected 0", slave_low_cnt - sl0); end
        n_cmp++; if (rx_valid_cnt - rv0 != 0) begin n_bad++; $display("FAIL mismatch_rx_valid: got %0d, expected 0", rx_valid_cnt - rv0); end
        n_cmp++; if (rx_data !== 12'hABC) begin n_bad++; $display("FAIL mismatch_rx_data: got %h, expected abc", rx_data); end
    endtask

    task automatic test_early_nack();
        logic a0;
        logic [7:0] b1, b2;
        int td0 = tx_done_cnt;
        tx_data = 12'h0A5;
        m_start();
        m_write_byte(8'hB5, a0);
        m_read_byte(1'b0, b1);
        m_read_byte(1'b0, b2);
        n_cmp++; if (b1 !== 8'h0A) begin n_bad++; $display("FAIL nack_byte1: got %h, expected 0a", b1); end
        n_cmp++; if (b2 !== 8'hFF) begin n_bad++; $display("FAIL nack_byte2_released: got %h, expected ff", b2); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL nack_busy_wait_stop: got %b, expected 1", busy); end
        m_stop();
        n_cmp++; if (tx_done_cnt - td0 != 0) begin n_bad++; $display("FAIL nack_tx_done: got %0d, expected 0", tx_done_cnt - td0); end
    endtask

    task automatic test_abort_restart();
        logic a;
        logic [7:0] abort_bits = 8'hB4;
        int rv0 = rx_valid_cnt;
        m_start();
        for (int i = 7; i >= 3; i--) m_bit_out(abort_bits[i]);
        m_stop();
        m_start();
        m_write_byte(8'hB4, a);
        m_write_byte(8'h5F, a);
        m_write_byte(8'h00, a);
        m_stop();
        n_cmp++; if (rx_valid_cnt - rv0 != 1) begin n_bad++; $display("FAIL abort_rx_valid_pulses: got %0d, expected 1", rx_valid_cnt - rv0); end
        n_cmp++; if (rx_data !== 12'h5F0) begin n_bad++; $display("FAIL abort_rx_data: got %h, expected 5f0", rx_data); end
        rv0 = rx_valid_cnt;
        m_start();
        m_write_byte(8'hB4, a);
        m_write_byte(8'h12, a);
        for (int i = 0; i < 3; i++) m_bit_out(1'b1);
        m_start();
        m_write_byte(8'hB4, a);
        m_write_byte(8'h34, a);
        m_write_byte(8'h50, a);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL restart_last_ack: got %b, expected 1", a); end
        m_stop();
        n_cmp++; if (rx_valid_cnt - rv0 != 1) begin n_bad++; $display("FAIL restart_rx_valid_pulses: got %0d, expected 1", rx_valid_cnt - rv0); end
        n_cmp++; if (rx_data !== 12'h345) begin n_bad++; $display("FAIL restart_rx_data: got %h, expected 345", rx_data); end
    endtask

    task automatic test_reset_mid();
        logic a;
        logic seen = 1'b0;
        int rv0;
        tx_data = 12'h3D7;
        m_start();
        m_write_byte(8'hB5, a);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (sda === 1'b0 && !m_sda_low) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rstmid_slave_drives_0: got %b, expected 1", seen); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL rstmid_sda_released: got %b, expected 1", sda); end
        n_cmp++; if ({rx_data, rx_valid, tx_done, busy} !== 15'h0) begin
            n_bad++; $display("FAIL rstmid_outputs: got %h, expected 0000", {rx_data, rx_valid, tx_done, busy});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rv0 = rx_valid_cnt;
        m_start();
        m_write_byte(8'hB4, a);
        m_write_byte(8'h00, a);
        m_write_byte(8'h10, a);
        m_stop();
        n_cmp++; if (rx_valid_cnt - rv0 != 1) begin n_bad++; $display("FAIL rstmid_rx_valid_pulses: got %0d, expected 1", rx_valid_cnt - rv0); end
        n_cmp++; if (rx_data !== 12'h001) begin n_bad++; $display("FAIL rstmid_rx_data: got %h, expected 001", rx_data); end
    endtask

    task automatic test_bus_discipline();
        n_cmp++; if (scl_high_change != 0) begin n_bad++; $display("FAIL sda_change_while_scl_high: got %0d, expected 0", scl_high_change); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_early_nack();
        test_abort_restart();
        test_reset_mid();
        test_bus_discipline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- 7-bit-address I2C target that sits on the same SDA/SCL bus as the team's I2C master and consumes its transactions.
- Every transaction carries a 12-bit word as two bytes on the wire:
  - byte 1 = data[11:4]
  - byte 2 = {data[3:0], 4'b0000}
- Writes deliver a received word to local logic. Reads return a word supplied by local logic.
- SCL is observed only; there is no clock stretching.

Parameters:
- SLAVE_ADDR, 7'h5A, 7-bit bus address this target responds to.

Ports:
- clk  input  1  system clock; period must be ≤ 1/4 of one tick_4x period of the bus master.
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  bus clock, observed only.
- sda  inout  1  bus data, open-drain: driven 0 or released to 'z'.
- tx_data  input  12  word returned on reads; sampled at address match.
- rx_data  output  12  last word received by a write.
- rx_valid  output  1  1-clk pulse when rx_data is updated.
- tx_done  output  1  1-clk pulse when a read word completes (second byte NACKed by master).
- busy  output  1  high from address match until STOP or next START.

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: sda released, rx_data=0, rx_valid=0, tx_done=0, busy=0, state IDLE, bit counter 0.
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer.
  - Edges are detected on the synchronized values: rise, fall, and previous value.
- Bus conditions:
  - START: sda falls while scl high.
  - STOP: sda rises while scl high.
  - Data sampled on scl rise; slave changes sda only on scl fall.
  - Slave never changes sda while scl high.
- Conditions take precedence over data activity in any state:
  - START → ADDR, counter cleared, sda released, busy=0.
  - STOP → IDLE, sda released, busy=0. A partial byte is discarded and rx_valid is not pulsed.
- FSM states: IDLE, ADDR, ADDR_ACK, RX_B1, RX_ACK1, RX_B2, RX_ACK2, TX_B1, TX_ACK1, TX_B2, TX_ACK2, WAIT_STOP.
- ADDR: shift in 8 bits MSB first; {addr[6:0], rw}.
- Address decision, on the 8th rise:
  - addr==SLAVE_ADDR: go to ADDR_ACK and set busy=1. If rw=1, latch tx_data into the tx shadow.
  - Otherwise: go to WAIT_STOP and never drive sda.
- Slave ACK, in ADDR_ACK, RX_ACK1 and RX_ACK2:
  - Pull sda low on the scl fall after the 8th data rise.
  - Hold low through the ACK high pulse.
  - Release on the following scl fall.
  - Exception: in a read, that fall instead drives the first TX bit.
- After ADDR_ACK: rw=0 → RX_B1; rw=1 → TX_B1.
- Write path:
  - RX_B1 shifts 8 bits into rx_hold[11:4].
  - RX_B2 shifts 8 bits; bits 7:4 → rx_hold[3:0]; pad bits are ignored, any value.
  - On the scl fall ending RX_ACK2: rx_data ← rx_hold, rx_valid pulses once, state → WAIT_STOP.
- Read path:
  - TX_B1 drives shadow[11:4] MSB first. Each bit is set on scl fall: sda released for 1, pulled low for 0.
  - TX_ACK1: release sda and sample on rise. 0 (ACK) → TX_B2. 1 (NACK) → WAIT_STOP, with no tx_done.
  - TX_B2 drives shadow[3:0], then four 0 pad bits.
  - TX_ACK2: release sda and sample. Either value → tx_done pulse, then WAIT_STOP.
- WAIT_STOP: sda released; exits only on STOP (→ IDLE) or START (→ ADDR).
- tx_data is not re-sampled mid-read; the shadow holds the value captured at address match.
- Reset mid-transfer: immediately release sda and return to reset values. The next action is a clean START.

Test Plan:
- Write: SLAVE_ADDR=7'h5A, master writes 12'hABC (wire bytes 0xB4, 0xAB, 0xC0) → ACK on all 3 bytes, rx_valid one pulse, rx_data=12'hABC, busy deasserts after STOP.
- Read: tx_data=12'h3D7, master reads → slave ACKs 0xB5 and drives 0x3D then 0x70. Master data_out=12'h3D7, exactly one tx_done pulse, sda released after M_NACK.
- Address mismatch: master addresses 7'h22 write 12'h123 → sda never driven by slave, master ack_err=1, rx_valid never pulses, rx_data unchanged.
- Early NACK: bench-driven master NACKs after read byte 1 → slave releases sda for byte 2, enters WAIT_STOP, tx_done stays 0.
- Abort and restart:
  - Stimulus: STOP injected after 5 bits of write byte 1, then a full write of 12'h5F0.
  - Required response: no rx_valid for the aborted transfer; rx_data=12'h5F0 after the second transfer.
  - Repeated START mid-RX_B2 likewise restarts at ADDR.
- Reset mid-transfer: assert rst while slave is driving a 0 in TX_B1 → sda released within same clk (async), outputs at reset values, next full write of 12'h001 succeeds.
